// File: rtl/axi_mem_rd_responder.sv
// AXI read-only responder in front of a synchronous single-port memory.
// Each AR burst is served one beat at a time: FETCH -> LOAD -> RESP.
// Optional out-of-range decode error: define AXI_MEM_RD_DECERR_EN.
// IdWidth defaults to the ID_R_WIDTH macro (4 if not defined elsewhere).

`ifndef ID_R_WIDTH
`define ID_R_WIDTH 4
`endif

module axi_mem_rd_responder #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth = `ID_R_WIDTH,
    parameter logic [AddrWidth-1:0] BaseAddr = AddrWidth'(32'h0000_0000),
    parameter int unsigned MemWords = 1024,
    localparam int unsigned MemAw = (MemWords > 1) ? $clog2(MemWords) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 arvalid_i,
    output logic                 arready_o,
    input  logic [IdWidth-1:0]   arid_i,
    input  logic [AddrWidth-1:0] araddr_i,
    input  logic [7:0]           arlen_i,
    input  logic [2:0]           arsize_i,
    input  logic [1:0]           arburst_i,
    output logic                 rvalid_o,
    input  logic                 rready_i,
    output logic [IdWidth-1:0]   rid_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic [1:0]           rresp_o,
    output logic                 rlast_o,
    output logic                 mem_en_o,
    output logic [MemAw-1:0]     mem_addr_o,
    input  logic [DataWidth-1:0] mem_rdata_i
);

    localparam int unsigned NumBytes = DataWidth / 8;
    localparam int unsigned ByteSh = $clog2(NumBytes);
    localparam logic [2:0] MaxSize = 3'(ByteSh);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, RESP} state_e;
    typedef enum logic [1:0] {BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10} burst_e;

    state_e               state_q, state_d;
    burst_e               burst_q, burst_d, ar_burst;
    logic                 arready_q, arready_d;
    logic                 mem_en_q, mem_en_d;
    logic                 rvalid_q, rvalid_d;
    logic                 rlast_q, rlast_d;
    logic [1:0]           rresp_q, rresp_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic [IdWidth-1:0]   rid_q, rid_d;
    logic [IdWidth-1:0]   id_q, id_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [7:0]           len_q, len_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [2:0]           size_q, size_d;
    logic                 slverr_q, slverr_d;

    logic [AddrWidth-1:0] addr_nxt;
    logic [AddrWidth-1:0] word_off;
    logic                 ar_oor, nxt_oor, cur_oor;

    // Address of the following beat; WRAP stays inside its aligned window
    function automatic logic [AddrWidth-1:0] next_addr(
        input logic [AddrWidth-1:0] a,
        input logic [7:0]           len,
        input logic [2:0]           size,
        input burst_e               burst
    );
        logic [AddrWidth-1:0] step, mask;
        step = AddrWidth'(1) << size;
        mask = ((AddrWidth'(len) + AddrWidth'(1)) << size) - AddrWidth'(1);
        case (burst)
            BURST_FIXED: next_addr = a;
            BURST_WRAP:  next_addr = (a & ~mask) | ((a + step) & mask);
            default:     next_addr = a + step;
        endcase
    endfunction

`ifdef AXI_MEM_RD_DECERR_EN
    localparam logic [AddrWidth:0] MemEnd = {1'b0, BaseAddr} + (AddrWidth+1)'(MemWords * NumBytes);

    function automatic logic out_of_range(input logic [AddrWidth-1:0] a);
        out_of_range = (a < BaseAddr) || ({1'b0, a} >= MemEnd);
    endfunction

    assign ar_oor  = out_of_range(araddr_i);
    assign nxt_oor = out_of_range(addr_nxt);
    assign cur_oor = out_of_range(addr_q);
`else
    assign ar_oor  = 1'b0;
    assign nxt_oor = 1'b0;
    assign cur_oor = 1'b0;
`endif

    // Burst-type normalisation at AR time: illegal WRAP lengths and 2'b11 act as INCR
    always_comb begin
        ar_burst = BURST_INCR;
        if (arburst_i == 2'b00) begin
            ar_burst = BURST_FIXED;
        end else if (arburst_i == 2'b10 &&
                     (arlen_i == 8'd1 || arlen_i == 8'd3 || arlen_i == 8'd7 || arlen_i == 8'd15)) begin
            ar_burst = BURST_WRAP;
        end
    end

    assign addr_nxt   = next_addr(addr_q, len_q, size_q, burst_q);
    assign word_off   = (addr_q - BaseAddr) >> ByteSh;
    assign mem_addr_o = MemAw'(word_off % AddrWidth'(MemWords));

    // Next-state and registered-output logic for the beat sequencer
    always_comb begin
        state_d   = state_q;
        burst_d   = burst_q;
        arready_d = arready_q;
        mem_en_d  = 1'b0;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        rid_d     = rid_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        size_d    = size_q;
        slverr_d  = slverr_q;
        unique case (state_q)
            IDLE: begin
                arready_d = 1'b1;
                if (arvalid_i && arready_q) begin
                    arready_d = 1'b0;
                    id_d      = arid_i;
                    addr_d    = araddr_i;
                    len_d     = arlen_i;
                    size_d    = arsize_i;
                    burst_d   = ar_burst;
                    cnt_d     = '0;
                    slverr_d  = (arsize_i > MaxSize);
                    mem_en_d  = ~ar_oor;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                rvalid_d = 1'b1;
                rlast_d  = (cnt_q == len_q);
                rid_d    = id_q;
                rresp_d  = slverr_q ? 2'b10 : (cur_oor ? 2'b11 : 2'b00);
                rdata_d  = cur_oor ? '0 : mem_rdata_i;
                state_d  = RESP;
            end
            RESP: begin
                if (rready_i) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    if (rlast_q) begin
                        arready_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cnt_d    = cnt_q + 8'd1;
                        addr_d   = addr_nxt;
                        mem_en_d = ~nxt_oor;
                        state_d  = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            burst_q   <= BURST_INCR;
            arready_q <= 1'b0;
            mem_en_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            rid_q     <= '0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            slverr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            arready_q <= arready_d;
            mem_en_q  <= mem_en_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            rid_q     <= rid_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            size_q    <= size_d;
            slverr_q  <= slverr_d;
        end
    end

    assign arready_o = arready_q;
    assign mem_en_o  = mem_en_q;
    assign rvalid_o  = rvalid_q;
    assign rlast_o   = rlast_q;
    assign rresp_o   = rresp_q;
    assign rdata_o   = rdata_q;
    assign rid_o     = rid_q;

endmodule

// File: tb/tb_axi_mem_rd_responder.sv
// Bench for axi_mem_rd_responder: directed table, reset-abort sequence,
// and randomized bursts against an arithmetic burst/address model.

module tb_axi_mem_rd_responder;

    localparam int MEMW = 1024;
`ifdef AXI_MEM_RD_DECERR_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arvalid = 1'b0;
    logic        arready_o;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        rvalid_o;
    logic        rready = 1'b1;
    logic [3:0]  rid_o;
    logic [31:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        rlast_o;
    logic        mem_en_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    axi_mem_rd_responder #(
        .AddrWidth(32),
        .DataWidth(32),
        .IdWidth(4),
        .BaseAddr(32'h0000_0000),
        .MemWords(MEMW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .arvalid_i(arvalid), .arready_o(arready_o), .arid_i(arid),
        .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
        .rvalid_o(rvalid_o), .rready_i(rready), .rid_o(rid_o), .rdata_o(rdata_o),
        .rresp_o(rresp_o), .rlast_o(rlast_o),
        .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata)
    );

    // Synchronous memory: data appears the cycle after the strobe, junk otherwise
    logic [31:0] mem [MEMW];
    always @(posedge clk) begin
        if (mem_en_o) mem_rdata <= mem[mem_addr_o];
        else          mem_rdata <= $urandom;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Byte address of beat i, straight from the burst rules
    function automatic logic [31:0] m_addr(input logic [31:0] a, input int unsigned len,
                                           input int unsigned size, input logic [1:0] bt,
                                           input int unsigned i);
        longint unsigned nb, win, base, aa;
        aa  = a;
        nb  = 64'd1 << size;
        win = (len + 1) * nb;
        if (bt == 2'b00) return a;
        if (bt == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            base = aa - (aa % win);
            return 32'(base + ((aa - base) + i * nb) % win);
        end
        return 32'(aa + i * nb);
    endfunction

    function automatic int unsigned m_word(input logic [31:0] a);
        return (a >> 2) % MEMW;
    endfunction

    function automatic bit m_oor(input logic [31:0] a);
        return DEC && (longint'(a) >= longint'(MEMW * 4));
    endfunction

    logic [31:0] obs_w [16];
    logic [1:0]  obs_resp [16];
    logic [31:0] obs_d [16];

    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input int unsigned len,
                             input int unsigned size, input logic [1:0] bt,
                             input int stall_beat, input int stall_len);
        logic [31:0] ba, ed;
        logic [1:0]  er;
        int unsigned w;
        bit          o, last;
        int          lat, men;
        @(negedge clk);
        chk("arready_idle", arready_o, 1);
        arvalid = 1'b1; arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = bt;
        @(posedge clk);
        for (int b = 0; b <= int'(len); b++) begin
            ba   = m_addr(addr, len, size, bt, b);
            w    = m_word(ba);
            o    = m_oor(ba);
            er   = (size > 2) ? 2'b10 : (o ? 2'b11 : 2'b00);
            ed   = o ? 32'h0 : mem[w];
            last = (b == int'(len));
            @(negedge clk);
            arvalid = 1'b0; araddr = $urandom; arid = 4'($urandom);
            lat = 1; men = 0; obs_w[b] = 'x;
            while (!rvalid_o && lat < 20) begin
                chk("arready_busy", arready_o, 0);
                if (mem_en_o) begin men++; obs_w[b] = 32'(mem_addr_o); end
                @(negedge clk);
                lat++;
            end
            chk("rvalid_seen", rvalid_o, 1);
            if (!rvalid_o) return;
            chk("beat_latency", lat, 3);
            chk("mem_en_pulses", men, o ? 0 : 1);
            if (!o) chk("mem_addr", obs_w[b], w);
            chk("rid", rid_o, id);
            chk("rresp", rresp_o, er);
            chk("rlast", rlast_o, last);
            chk("mem_en_in_resp", mem_en_o, 0);
            if (er != 2'b10) chk("rdata", rdata_o, ed);
            obs_resp[b] = rresp_o;
            obs_d[b]    = rdata_o;
            if (b == stall_beat && stall_len > 0) begin
                rready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    chk("stall_ctrl", {rvalid_o, rid_o, rresp_o, rlast_o}, {1'b1, id, er, last});
                    if (er != 2'b10) chk("stall_data", rdata_o, ed);
                end
                rready = 1'b1;
            end
            @(posedge clk);
        end
        @(negedge clk);
        chk("post_burst_rvalid", rvalid_o, 0);
        chk("post_burst_arready", arready_o, 1);
    endtask

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        int unsigned len;
        int unsigned size;
        logic [1:0]  bt;
        int          stall_beat;
        int          stall_len;
        bit          oor;
        int unsigned w [4];
        logic [1:0]  resp0;
        bit          chk_d;
        logic [31:0] d0;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] id, input logic [31:0] addr, input int unsigned len,
                                input int unsigned size, input logic [1:0] bt, input int sb, input int sl,
                                input bit oor, input int unsigned w0, input int unsigned w1,
                                input int unsigned w2, input int unsigned w3, input logic [1:0] r0,
                                input bit cd, input logic [31:0] d0);
        vec_t v;
        v.id = id; v.addr = addr; v.len = len; v.size = size; v.bt = bt;
        v.stall_beat = sb; v.stall_len = sl; v.oor = oor;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.resp0 = r0; v.chk_d = cd; v.d0 = d0;
        return v;
    endfunction

    vec_t vecs [11];

    initial begin
        logic [1:0]  oor_resp;
        logic [31:0] ra;
        int          k;
        oor_resp = DEC ? 2'b11 : 2'b00;
        for (int i = 0; i < MEMW; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[4] = 32'hDEAD_BEEF;

        vecs[0]  = mk(4'h1, 32'h10,       0, 2, 2'b01, -1, 0, 0, 4, 0, 0, 0, 2'b00, 1, 32'hDEAD_BEEF);
        vecs[1]  = mk(4'h2, 32'h0,        3, 2, 2'b01,  1, 5, 0, 0, 1, 2, 3, 2'b00, 0, 32'h0);
        vecs[2]  = mk(4'h3, 32'h38,       3, 2, 2'b10, -1, 0, 0, 14, 15, 12, 13, 2'b00, 0, 32'h0);
        vecs[3]  = mk(4'h5, 32'h20,       2, 2, 2'b00,  2, 2, 0, 8, 8, 8, 0, 2'b00, 0, 32'h0);
        vecs[4]  = mk(4'h6, 32'h1000,     0, 2, 2'b01, -1, 0, 1, 0, 0, 0, 0, oor_resp, 1,
                      DEC ? 32'h0 : 32'hC0DE_0000);
        vecs[5]  = mk(4'h7, 32'h40,       1, 3, 2'b01, -1, 0, 0, 16, 18, 0, 0, 2'b10, 0, 32'h0);
        vecs[6]  = mk(4'h8, 32'h38,       2, 2, 2'b10, -1, 0, 0, 14, 15, 16, 0, 2'b00, 0, 32'h0);
        vecs[7]  = mk(4'h9, 32'h8,        1, 2, 2'b11, -1, 0, 0, 2, 3, 0, 0, 2'b00, 0, 32'h0);
        vecs[8]  = mk(4'hA, 32'hFFFF_FFFC, 1, 2, 2'b01, -1, 0, 1, 1023, 0, 0, 0, oor_resp, 0, 32'h0);
        vecs[9]  = mk(4'hB, 32'h3C,       1, 1, 2'b10, -1, 0, 0, 15, 15, 0, 0, 2'b00, 0, 32'h0);
        vecs[10] = mk(4'hC, 32'h6,        3, 1, 2'b10,  0, 1, 0, 1, 0, 0, 1, 2'b00, 0, 32'h0);

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_rlast", rlast_o, 0);
        chk("rst_mem_en", mem_en_o, 0);
        chk("rst_rresp", rresp_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_rid", rid_o, 0);
        chk("rst_arready", arready_o, 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("release_arready", arready_o, 1);

        // Directed table
        foreach (vecs[i]) begin
            run_burst(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].bt,
                      vecs[i].stall_beat, vecs[i].stall_len);
            for (int b = 0; b <= int'(vecs[i].len) && b < 4; b++)
                if (!(DEC && vecs[i].oor)) chk($sformatf("tbl%0d_waddr%0d", i, b), obs_w[b], vecs[i].w[b]);
            chk($sformatf("tbl%0d_resp0", i), obs_resp[0], vecs[i].resp0);
            if (vecs[i].chk_d) chk($sformatf("tbl%0d_data0", i), obs_d[0], vecs[i].d0);
        end

        // Reset during beat 2 of an 8-beat burst
        @(negedge clk);
        arvalid = 1'b1; arid = 4'hD; araddr = 32'h100; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01;
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        k = 0;
        while (!rvalid_o && k < 20) begin @(negedge clk); k++; end
        chk("abort_b0_valid", rvalid_o, 1);
        @(posedge clk);
        @(negedge clk);
        k = 0;
        while (!rvalid_o && k < 20) begin @(negedge clk); k++; end
        chk("abort_b1_valid", rvalid_o, 1);
        chk("abort_b1_data", rdata_o, mem[32'h41]);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_rvalid", rvalid_o, 0);
        chk("abort_arready_in_rst", arready_o, 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_arready_after", arready_o, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_beats", rvalid_o | mem_en_o, 0);
        end
        run_burst(4'hE, 32'h44, 1, 2, 2'b01, -1, 0);

        // Randomized bursts against the model
        for (int n = 0; n < 40; n++) begin
            int unsigned ln, sz;
            ln = $urandom_range(0, 15);
            sz = $urandom_range(0, 3);
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 4200));
            run_burst(4'($urandom), ra, ln, sz, 2'($urandom), int'($urandom_range(0, ln)),
                      int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

// File: doc/axi_mem_rd_responder.md
AXI_MEM_RD_RESPONDER -- requirements
Module: axi_mem_rd_responder

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- AddrWidth, 32, AR address width.
- DataWidth, 32, R data width; power of two, at least 8.
- IdWidth, `ID_R_WIDTH, AR/R ID width.
- BaseAddr, 32'h0000_0000, first byte address served.
- MemWords, 1024, words in the backing memory.

REQ-002 SHALL have ports, one per line: name, direction, width, meaning. Clock and reset are first: one clock, reset synchronous and active-high.
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- arvalid_i, in, 1, AR valid.
- arready_o, out, 1, AR ready.
- arid_i, in, IdWidth, AR ID.
- araddr_i, in, AddrWidth, AR byte address.
- arlen_i, in, 8, beats minus 1.
- arsize_i, in, 3, log2 bytes per beat.
- arburst_i, in, 2, 00 FIXED, 01 INCR, 10 WRAP.
- rvalid_o, out, 1, R valid.
- rready_i, in, 1, R ready.
- rid_o, out, IdWidth, R ID.
- rdata_o, out, DataWidth, R data.
- rresp_o, out, 2, R response.
- rlast_o, out, 1, last beat.
- mem_en_o, out, 1, memory read strobe.
- mem_addr_o, out, $clog2(MemWords), word address.
- mem_rdata_i, in, DataWidth, read data, valid the cycle after mem_en_o.

Function
REQ-003 SHALL implement an FSM with four states:
- IDLE: arready_o=1.
- FETCH: mem_en_o=1 for exactly one cycle.
- LOAD: capture mem_rdata_i into rdata_o.
- RESP: rvalid_o=1.

REQ-004 SHALL take an AR handshake in IDLE at cycle 0, latch arid/araddr/arlen/arsize/arburst, and move to FETCH.
- FETCH is at cycle 1, LOAD at cycle 2, first rvalid_o at cycle 3.

REQ-005 SHALL take the following action on an R handshake in RESP:
- Non-last beat: advance the address and beat counter, then go to FETCH. Each beat costs 3 cycles plus stall.
- Last beat: go to IDLE.

REQ-006 SHALL hold rvalid_o, rdata_o, rid_o, rresp_o and rlast_o stable while rvalid_o=1 and rready_i=0.

REQ-007 SHALL drive rlast_o=1 only when the beat counter equals the latched arlen; arlen=0 yields a single beat with rlast_o=1.

REQ-008 SHALL drive rid_o with the latched arid for every beat of the burst.

REQ-009 SHALL compute the next address by burst type:
- FIXED: unchanged.
- INCR: addr + (1<<arsize), wrapping modulo 2^AddrWidth.
- WRAP: increment within a (arlen+1)*(1<<arsize)-byte aligned window, returning to the window base at its top.

REQ-010 SHALL treat WRAP with arlen not in {1,3,7,15}, and burst type 11, as INCR.

REQ-011 SHALL drive mem_addr_o = ((addr - BaseAddr) >> log2(DataWidth/8)) modulo MemWords.

REQ-012 SHALL return rresp_o=2'b10 (SLVERR) for every beat when arsize > log2(DataWidth/8); otherwise 2'b00 (OKAY), subject to REQ-018.

REQ-013 SHALL keep arready_o=0 in every non-IDLE state, so only one burst is outstanding.

REQ-014 SHALL keep mem_en_o=0 outside FETCH.

Reset
REQ-015 SHALL, on rst_i=1 at a clk_i edge, enter IDLE and clear outputs:
- rvalid_o=0, rlast_o=0, mem_en_o=0, rresp_o=0, rdata_o=0, rid_o=0.
- arready_o=0 while rst_i=1; arready_o=1 in the first cycle after release.

REQ-016 SHALL, on reset mid-burst, abort the burst with no further beats; rvalid_o is low by the next edge.

REQ-017 SHALL have no asynchronous reset paths.

Configuration
REQ-018 SHALL compile out-of-range checking under macro AXI_MEM_RD_DECERR_EN.
- Defined: beats with addr < BaseAddr or addr >= BaseAddr + MemWords*(DataWidth/8) return rresp_o=2'b11 and rdata_o=0. FETCH still occurs with mem_en_o=0. SLVERR (REQ-012) takes priority.
- Undefined: no check; addresses alias per REQ-011 with OKAY.

Verification
REQ-019 SHALL cover the following directed scenarios:
- INCR single beat: araddr=0x10, arlen=0, arsize=2, memory word 4 = 0xDEADBEEF -> rvalid_o at cycle 3; rdata_o=0xDEADBEEF, rlast_o=1, rresp_o=00.
- INCR 4-beat with backpressure: araddr=0x0, arlen=3, rready_i low 5 cycles on beat 2 -> mem_addr_o 0,1,2,3; beat-2 outputs stable throughout the stall; rlast_o only on beat 4.
- WRAP 4-beat: araddr=0x38, arlen=3, arsize=2 -> word addresses 14,15,12,13.
- FIXED 3-beat: araddr=0x20 -> mem_addr_o=8 on all beats; rid_o equals arid_i=0x5 on all beats.
- Reset at beat 2 of an 8-beat burst -> rvalid_o=0 the next cycle; arready_o=1 after release; a new AR is accepted normally.
- With AXI_MEM_RD_DECERR_EN: araddr=BaseAddr+MemWords*4 -> rresp_o=11, rdata_o=0, mem_en_o never high. Without the macro -> rresp_o=00, word 0 returned.
